// File: rtl/conv_pkg.sv
// ----------------------------------------------------------------------------
// conv_pkg
// Definitions shared by the CNN convolution datapath blocks (operand fetch,
// MAC, controller).
//   BITWIDTH_DEFAULT : default element width (fp16 raw bits)
//   result_dim()     : output dimension of a strided, padded convolution
//   msb_slice_lo()   : low bit of element k in an MSB-first packed vector
// ----------------------------------------------------------------------------
package conv_pkg;

    localparam int BITWIDTH_DEFAULT = 16;

    // Output size along one axis. pad is the effective per-side padding.
    function automatic int result_dim(input int img_dim, input int ker_dim,
                                      input int pad, input int stride);
        return (img_dim - ker_dim + 2 * pad) / stride + 1;
    endfunction

    // Element 0 sits at the MSB end of the packed vector.
    function automatic int msb_slice_lo(input int n_elem, input int k,
                                        input int width);
        return (n_elem - 1 - k) * width;
    endfunction

endpackage

// File: rtl/conv_pad_fetch.sv
// ----------------------------------------------------------------------------
// conv_pad_fetch
// Combinational image-side operand select. Maps an output anchor plus a
// decoded kernel tap to an image coordinate, checks it against the image
// bounds (the padding region reads as zero) and muxes out the element.
// Ports:
//   img      in  packed image, expand planes, element 0 at the MSB
//   anchor_l in  output row index
//   anchor_c in  output column index
//   tap_ch   in  channel of the kernel tap
//   tap_kr   in  kernel row within the channel
//   tap_kc   in  kernel column
//   elem     out selected image element, zero in the padding region
// ----------------------------------------------------------------------------
module conv_pad_fetch
    import conv_pkg::*;
#(
    parameter int img_width  = 4,
    parameter int img_height = 4,
    parameter int expand     = 1,
    parameter int bitwidth   = BITWIDTH_DEFAULT,
    parameter int stride     = 1,
    parameter int pad_eff    = 0
) (
    input  logic [img_height*img_width*expand*bitwidth-1:0] img,
    input  logic [31:0]                                     anchor_l,
    input  logic [31:0]                                     anchor_c,
    input  logic [3:0]                                      tap_ch,
    input  logic [3:0]                                      tap_kr,
    input  logic [3:0]                                      tap_kc,
    output logic [bitwidth-1:0]                             elem
);

    localparam int IMG_N = img_height * img_width * expand;
    localparam int IDX_W = (IMG_N > 1) ? $clog2(IMG_N) : 1;
    // 34 bits: a 32-bit anchor scaled by stride, minus padding, stays signed.
    localparam int CW = 34;
    localparam logic signed [CW-1:0] STRIDE_S = CW'(stride);
    localparam logic signed [CW-1:0] PAD_S    = CW'(pad_eff);
    localparam logic signed [CW-1:0] IMG_H_S  = CW'(img_height);
    localparam logic signed [CW-1:0] IMG_W_S  = CW'(img_width);

    logic [bitwidth-1:0] plane [IMG_N];

    for (genvar k = 0; k < IMG_N; k++) begin : g_unpack
        assign plane[k] = img[msb_slice_lo(IMG_N, k, bitwidth) +: bitwidth];
    end

    logic signed [CW-1:0] row;
    logic signed [CW-1:0] col;
    logic                 in_range;
    logic [IDX_W-1:0]     idx;
    int                   lin;

    always_comb begin
        // NOTE: every variable gets a default before any branch so no path
        // leaves it unassigned; otherwise synthesis infers a latch.
        lin  = 0;
        idx  = '0;
        elem = '0;

        row = $signed({2'b00, anchor_l}) * STRIDE_S + $signed(CW'(tap_kr)) - PAD_S;
        col = $signed({2'b00, anchor_c}) * STRIDE_S + $signed(CW'(tap_kc)) - PAD_S;

        in_range = (row >= 0) && (row < IMG_H_S) &&
                   (col >= 0) && (col < IMG_W_S) &&
                   (int'(tap_ch) < expand);

        if (in_range) begin
            lin  = int'(tap_ch) * img_height * img_width
                 + int'(row[31:0]) * img_width
                 + int'(col[31:0]);
            idx  = IDX_W'(lin);
            elem = plane[idx];
        end
    end

endmodule

// File: rtl/conv_buffer.sv
// ----------------------------------------------------------------------------
// conv_buffer
// Operand fetch stage of the convolution datapath. Each cycle selects one
// image element and the matching kernel weight for a single MAC step and
// registers both (latency 1, one pair per cycle).
// Ports:
//   clk_en   in  clock, rising edge
//   rst_n    in  synchronous reset, active-high despite the name
//   conv_on  in  fetch enable
//   img      in  packed image (expand planes, element 0 at the MSB)
//   weight   in  packed kernel (expand planes, element 0 at the MSB)
//   anchor_l in  output row index
//   anchor_c in  output column index
//   buf_l    in  channel-stacked kernel row tap
//   buf_c    in  kernel column tap
//   img_cal  out registered image operand
//   wei_cal  out registered weight operand
// Configuration macro: CONV_BUFFER_HOLD_EN -- when defined, conv_on=0 holds
// the outputs; when undefined, conv_on=0 clears them every edge.
// ----------------------------------------------------------------------------
module conv_buffer
    import conv_pkg::*;
#(
    parameter int weight_width   = 2,
    parameter int weight_height  = 2,
    parameter int img_width      = 4,
    parameter int img_height     = 4,
    parameter int padding_enable = 0,
    parameter int padding        = 0,
    parameter int stride         = 1,
    parameter int bitwidth       = BITWIDTH_DEFAULT,
    parameter int result_width   = result_dim(img_width, weight_width,
                                              (padding_enable != 0) ? padding : 0, stride),
    parameter int result_height  = result_dim(img_height, weight_height,
                                              (padding_enable != 0) ? padding : 0, stride),
    parameter int expand         = 1
) (
    input  logic                                                clk_en,
    input  logic                                                rst_n,
    input  logic                                                conv_on,
    input  logic [img_height*img_width*expand*bitwidth-1:0]     img,
    input  logic [weight_height*weight_width*expand*bitwidth-1:0] weight,
    input  logic [31:0]                                         anchor_l,
    input  logic [31:0]                                         anchor_c,
    input  logic [3:0]                                          buf_l,
    input  logic [3:0]                                          buf_c,
    output logic [bitwidth-1:0]                                 img_cal,
    output logic [bitwidth-1:0]                                 wei_cal
);

    localparam int PAD_EFF = (padding_enable != 0) ? padding : 0;
    localparam int W_N     = weight_height * weight_width * expand;
    localparam int W_IDX_W = (W_N > 1) ? $clog2(W_N) : 1;

    // Tap decode: buf_l walks the channel-stacked kernel rows.
    logic [3:0] tap_ch;
    logic [3:0] tap_kr;
    logic       sel_valid;

    always_comb begin
        tap_ch = 4'(int'(buf_l) / weight_height);
        tap_kr = 4'(int'(buf_l) % weight_height);
    end

    // Any out-of-range anchor or tap zeroes both operands.
    assign sel_valid = (anchor_l < 32'(result_height)) &&
                       (anchor_c < 32'(result_width))  &&
                       (int'(buf_l) < weight_height * expand) &&
                       (int'(buf_c) < weight_width);

    logic [bitwidth-1:0] img_elem;

    conv_pad_fetch #(
        .img_width  (img_width),
        .img_height (img_height),
        .expand     (expand),
        .bitwidth   (bitwidth),
        .stride     (stride),
        .pad_eff    (PAD_EFF)
    ) u_pad_fetch (
        .img      (img),
        .anchor_l (anchor_l),
        .anchor_c (anchor_c),
        .tap_ch   (tap_ch),
        .tap_kr   (tap_kr),
        .tap_kc   (buf_c),
        .elem     (img_elem)
    );

    // Weight mux.
    logic [bitwidth-1:0] kernel [W_N];

    for (genvar k = 0; k < W_N; k++) begin : g_kernel
        assign kernel[k] = weight[msb_slice_lo(W_N, k, bitwidth) +: bitwidth];
    end

    logic [bitwidth-1:0] wei_elem;
    logic [W_IDX_W-1:0]  w_idx;
    int                  w_lin;

    always_comb begin
        w_lin    = 0;
        w_idx    = '0;
        wei_elem = '0;
        if (sel_valid) begin
            w_lin    = int'(tap_ch) * weight_height * weight_width
                     + int'(tap_kr) * weight_width
                     + int'(buf_c);
            w_idx    = W_IDX_W'(w_lin);
            wei_elem = kernel[w_idx];
        end
    end

    // Output registers; reset wins over conv_on.
    always_ff @(posedge clk_en) begin
        // NOTE: non-blocking assignments so every register samples the
        // pre-edge values, independent of statement order.
        if (rst_n) begin
            img_cal <= '0;
            wei_cal <= '0;
        end else if (conv_on) begin
            img_cal <= sel_valid ? img_elem : '0;
            wei_cal <= wei_elem;
        end else begin
`ifdef CONV_BUFFER_HOLD_EN
            img_cal <= img_cal;
            wei_cal <= wei_cal;
`else
            img_cal <= '0;
            wei_cal <= '0;
`endif
        end
    end

endmodule

// File: tb/tb_conv_buffer.sv
// ----------------------------------------------------------------------------
// tb_conv_buffer
// Directed bench for conv_buffer. Four instances share the control inputs:
//   u_base : default parameters (4x4 image, 2x2 kernel, result 3x3)
//   u_pad  : padding_enable=1, padding=1 (result 5x5)
//   u_str  : stride=2 (result 2x2)
//   u_exp  : expand=2 (two channels, distinct weights per channel)
// ----------------------------------------------------------------------------
module tb_conv_buffer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        conv_on;
    logic [31:0] anchor_l;
    logic [31:0] anchor_c;
    logic [3:0]  buf_l;
    logic [3:0]  buf_c;

    logic [255:0] img_a;
    logic [63:0]  wei_a;
    logic [511:0] img_x;
    logic [127:0] wei_x;

    logic [15:0] b_img, b_wei, p_img, p_wei, s_img, s_wei, x_img, x_wei;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    conv_buffer u_base (
        .clk_en (clk), .rst_n (rst_n), .conv_on (conv_on),
        .img (img_a), .weight (wei_a),
        .anchor_l (anchor_l), .anchor_c (anchor_c), .buf_l (buf_l), .buf_c (buf_c),
        .img_cal (b_img), .wei_cal (b_wei)
    );

    conv_buffer #(.padding_enable (1), .padding (1)) u_pad (
        .clk_en (clk), .rst_n (rst_n), .conv_on (conv_on),
        .img (img_a), .weight (wei_a),
        .anchor_l (anchor_l), .anchor_c (anchor_c), .buf_l (buf_l), .buf_c (buf_c),
        .img_cal (p_img), .wei_cal (p_wei)
    );

    conv_buffer #(.stride (2)) u_str (
        .clk_en (clk), .rst_n (rst_n), .conv_on (conv_on),
        .img (img_a), .weight (wei_a),
        .anchor_l (anchor_l), .anchor_c (anchor_c), .buf_l (buf_l), .buf_c (buf_c),
        .img_cal (s_img), .wei_cal (s_wei)
    );

    conv_buffer #(.expand (2)) u_exp (
        .clk_en (clk), .rst_n (rst_n), .conv_on (conv_on),
        .img (img_x), .weight (wei_x),
        .anchor_l (anchor_l), .anchor_c (anchor_c), .buf_l (buf_l), .buf_c (buf_c),
        .img_cal (x_img), .wei_cal (x_wei)
    );

    // Drive one selection, take one edge, sample 1 ns later.
    task automatic apply(input logic [31:0] al, input logic [31:0] ac,
                         input logic [3:0] bl, input logic [3:0] bc);
        anchor_l = al;
        anchor_c = ac;
        buf_l    = bl;
        buf_c    = bc;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n   = 1'b1;
        conv_on = 1'b1;
        apply(0, 0, 0, 0);
        apply(0, 0, 0, 0);
        n_checks++;
        if (b_img !== 16'h0000) begin
            n_errors++; $display("FAIL reset_img: got %h expected %h", b_img, 16'h0000);
        end
        n_checks++;
        if (b_wei !== 16'h0000) begin
            n_errors++; $display("FAIL reset_wei: got %h expected %h", b_wei, 16'h0000);
        end
        rst_n = 1'b0;
        apply(0, 0, 0, 0);
        n_checks++;
        if (b_img !== 16'h0001) begin
            n_errors++; $display("FAIL release_img: got %h expected %h", b_img, 16'h0001);
        end
        n_checks++;
        if (b_wei !== 16'h3C00) begin
            n_errors++; $display("FAIL release_wei: got %h expected %h", b_wei, 16'h3C00);
        end
    endtask

    // Output must not follow new inputs until the next edge.
    task automatic test_latency;
        apply(0, 0, 0, 0);
        anchor_l = 2; anchor_c = 2; buf_l = 1; buf_c = 1;
        #2;
        n_checks++;
        if (b_img !== 16'h0001) begin
            n_errors++; $display("FAIL latency_hold: got %h expected %h", b_img, 16'h0001);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (b_img !== 16'h0010) begin
            n_errors++; $display("FAIL anchor22_tap11: got %h expected %h", b_img, 16'h0010);
        end
    endtask

    task automatic test_sweep;
        logic [15:0] exp_v;
        for (int al = 0; al < 3; al++)
            for (int ac = 0; ac < 3; ac++)
                for (int kr = 0; kr < 2; kr++)
                    for (int kc = 0; kc < 2; kc++) begin
                        apply(32'(al), 32'(ac), 4'(kr), 4'(kc));
                        exp_v = 16'((al + kr) * 4 + (ac + kc) + 1);
                        n_checks++;
                        if (b_img !== exp_v || b_wei !== 16'h3C00) begin
                            n_errors++;
                            $display("FAIL sweep a(%0d,%0d) t(%0d,%0d): got %h/%h expected %h/%h",
                                     al, ac, kr, kc, b_img, b_wei, exp_v, 16'h3C00);
                        end
                    end
    endtask

    task automatic test_img_change;
        img_a[255 -: 16] = 16'hABCD;
        apply(0, 0, 0, 0);
        n_checks++;
        if (b_img !== 16'hABCD) begin
            n_errors++; $display("FAIL img_change: got %h expected %h", b_img, 16'hABCD);
        end
        img_a[255 -: 16] = 16'h0001;
        apply(0, 0, 0, 0);
        n_checks++;
        if (b_img !== 16'h0001) begin
            n_errors++; $display("FAIL img_restore: got %h expected %h", b_img, 16'h0001);
        end
    endtask

    task automatic test_padding;
        apply(0, 0, 0, 0);
        n_checks++;
        if (p_img !== 16'h0000 || p_wei !== 16'h3C00) begin
            n_errors++; $display("FAIL pad_corner: got %h/%h expected %h/%h", p_img, p_wei, 16'h0000, 16'h3C00);
        end
        apply(0, 0, 1, 1);
        n_checks++;
        if (p_img !== 16'h0001) begin
            n_errors++; $display("FAIL pad_tap11: got %h expected %h", p_img, 16'h0001);
        end
        apply(4, 4, 0, 0);
        n_checks++;
        if (p_img !== 16'h0010 || p_wei !== 16'h3C00) begin
            n_errors++; $display("FAIL pad_a44_t00: got %h/%h expected %h/%h", p_img, p_wei, 16'h0010, 16'h3C00);
        end
        // Same anchor is beyond the unpadded instance's 3x3 result grid.
        n_checks++;
        if (b_img !== 16'h0000 || b_wei !== 16'h0000) begin
            n_errors++; $display("FAIL base_anchor_oob: got %h/%h expected %h/%h", b_img, b_wei, 16'h0000, 16'h0000);
        end
        apply(4, 4, 1, 1);
        n_checks++;
        if (p_img !== 16'h0000 || p_wei !== 16'h3C00) begin
            n_errors++; $display("FAIL pad_a44_t11: got %h/%h expected %h/%h", p_img, p_wei, 16'h0000, 16'h3C00);
        end
    endtask

    task automatic test_stride;
        apply(1, 1, 1, 1);
        n_checks++;
        if (s_img !== 16'h0010 || s_wei !== 16'h3C00) begin
            n_errors++; $display("FAIL stride_a11_t11: got %h/%h expected %h/%h", s_img, s_wei, 16'h0010, 16'h3C00);
        end
        apply(1, 0, 0, 1);
        n_checks++;
        if (s_img !== 16'h000A) begin
            n_errors++; $display("FAIL stride_a10_t01: got %h expected %h", s_img, 16'h000A);
        end
        apply(2, 0, 0, 0);
        n_checks++;
        if (s_img !== 16'h0000 || s_wei !== 16'h0000) begin
            n_errors++; $display("FAIL stride_anchor_oob: got %h/%h expected %h/%h", s_img, s_wei, 16'h0000, 16'h0000);
        end
    endtask

    task automatic test_expand;
        apply(0, 0, 2, 0);
        n_checks++;
        if (x_img !== 16'h0011 || x_wei !== 16'h4000) begin
            n_errors++; $display("FAIL expand_ch1_t00: got %h/%h expected %h/%h", x_img, x_wei, 16'h0011, 16'h4000);
        end
        // buf_l=2 is past the single-channel kernel of the base instance.
        n_checks++;
        if (b_img !== 16'h0000 || b_wei !== 16'h0000) begin
            n_errors++; $display("FAIL base_tap_oob: got %h/%h expected %h/%h", b_img, b_wei, 16'h0000, 16'h0000);
        end
        apply(2, 2, 3, 1);
        n_checks++;
        if (x_img !== 16'h0020 || x_wei !== 16'h4003) begin
            n_errors++; $display("FAIL expand_ch1_t11: got %h/%h expected %h/%h", x_img, x_wei, 16'h0020, 16'h4003);
        end
        apply(1, 0, 1, 1);
        n_checks++;
        if (x_img !== 16'h000A || x_wei !== 16'h3C03) begin
            n_errors++; $display("FAIL expand_ch0_t11: got %h/%h expected %h/%h", x_img, x_wei, 16'h000A, 16'h3C03);
        end
        apply(0, 0, 4, 0);
        n_checks++;
        if (x_img !== 16'h0000 || x_wei !== 16'h0000) begin
            n_errors++; $display("FAIL expand_buf_l_oob: got %h/%h expected %h/%h", x_img, x_wei, 16'h0000, 16'h0000);
        end
        apply(0, 0, 0, 2);
        n_checks++;
        if (x_img !== 16'h0000 || x_wei !== 16'h0000) begin
            n_errors++; $display("FAIL expand_buf_c_oob: got %h/%h expected %h/%h", x_img, x_wei, 16'h0000, 16'h0000);
        end
    endtask

    task automatic test_conv_off;
        logic [15:0] exp_img;
        logic [15:0] exp_wei;
        conv_on = 1'b1;
        apply(1, 1, 0, 0);
        n_checks++;
        if (b_img !== 16'h0006) begin
            n_errors++; $display("FAIL off_setup: got %h expected %h", b_img, 16'h0006);
        end
`ifdef CONV_BUFFER_HOLD_EN
        exp_img = 16'h0006;
        exp_wei = 16'h3C00;
`else
        exp_img = 16'h0000;
        exp_wei = 16'h0000;
`endif
        conv_on = 1'b0;
        for (int i = 0; i < 2; i++) begin
            apply(2, 2, 1, 1);
            n_checks++;
            if (b_img !== exp_img || b_wei !== exp_wei) begin
                n_errors++;
                $display("FAIL conv_off edge %0d: got %h/%h expected %h/%h", i, b_img, b_wei, exp_img, exp_wei);
            end
        end
        conv_on = 1'b1;
        apply(2, 2, 1, 1);
        n_checks++;
        if (b_img !== 16'h0010) begin
            n_errors++; $display("FAIL conv_resume: got %h expected %h", b_img, 16'h0010);
        end
    endtask

    task automatic test_mid_reset;
        apply(0, 1, 0, 0);
        apply(0, 2, 0, 1);
        n_checks++;
        if (b_img !== 16'h0004) begin
            n_errors++; $display("FAIL midrst_pre: got %h expected %h", b_img, 16'h0004);
        end
        rst_n = 1'b1;
        apply(1, 1, 1, 1);
        n_checks++;
        if (b_img !== 16'h0000 || b_wei !== 16'h0000 || x_img !== 16'h0000 || x_wei !== 16'h0000) begin
            n_errors++;
            $display("FAIL midrst_clear: got %h/%h %h/%h expected all 0000", b_img, b_wei, x_img, x_wei);
        end
        rst_n = 1'b0;
        apply(1, 1, 1, 1);
        n_checks++;
        if (b_img !== 16'h000B || b_wei !== 16'h3C00) begin
            n_errors++; $display("FAIL midrst_release: got %h/%h expected %h/%h", b_img, b_wei, 16'h000B, 16'h3C00);
        end
    endtask

    initial begin
        rst_n    = 1'b1;
        conv_on  = 1'b0;
        anchor_l = '0;
        anchor_c = '0;
        buf_l    = '0;
        buf_c    = '0;
        for (int k = 0; k < 16; k++) img_a[(15 - k) * 16 +: 16] = 16'(k + 1);
        for (int k = 0; k < 4; k++)  wei_a[(3 - k) * 16 +: 16]  = 16'h3C00;
        for (int k = 0; k < 32; k++) img_x[(31 - k) * 16 +: 16] = 16'(k + 1);
        for (int k = 0; k < 4; k++) begin
            wei_x[(7 - k) * 16 +: 16] = 16'h3C00 + 16'(k);
            wei_x[(3 - k) * 16 +: 16] = 16'h4000 + 16'(k);
        end

        test_reset;
        test_latency;
        test_sweep;
        test_img_change;
        test_padding;
        test_stride;
        test_expand;
        test_conv_off;
        test_mid_reset;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/conv_buffer.md
# conv_buffer

Operand fetch stage of the CNN convolution datapath. It holds a packed image plane and a packed kernel. Each cycle it selects one image element and the matching weight element for a single multiply-accumulate step. The step is addressed by an output anchor (anchor_l, anchor_c) and a kernel tap (buf_l, buf_c). Both operands are registered and go to the downstream MAC.

## Interface
- weight_width, 2: kernel columns
- weight_height, 2: kernel rows
- img_width, 4: image columns
- img_height, 4: image rows
- padding_enable, 0: 1 = zero padding active
- padding, 0: pad size in elements per side; ignored when padding_enable=0
- stride, 1: window step, ≥1
- bitwidth, 16: element width (fp16 raw bits, passed through untouched)
- result_width, (img_width-weight_width+2*padding)/stride+1: output columns
- result_height, (img_height-weight_height+2*padding)/stride+1: output rows
- expand, 1: channel count; image and kernel hold expand planes
- clk_en  in  1  clock, rising edge
- rst_n  in  1  reset; synchronous, active-high despite the name
- conv_on  in  1  fetch enable
- img  in  img_height*img_width*expand*bitwidth  packed image
- weight  in  weight_height*weight_width*expand*bitwidth  packed kernel
- anchor_l  in  32  output row index, 0..result_height-1
- anchor_c  in  32  output column index, 0..result_width-1
- buf_l  in  4  kernel row tap, 0..weight_height*expand-1 (channel-stacked)
- buf_c  in  4  kernel column tap, 0..weight_width-1
- img_cal  out  bitwidth  selected image element
- wei_cal  out  bitwidth  selected weight element

## Operation
- Packing: element k of a vector of N elements occupies bits [(N-1-k)*bitwidth +: bitwidth], so element 0 is at the MSB.
- Linear index: ch*H*W + r*W + c, where H/W are image or kernel dimensions.
- Tap decode: ch = buf_l / weight_height; kr = buf_l % weight_height; kc = buf_c.
- Image coordinate: r = anchor_l*stride + kr - padding_eff; c = anchor_c*stride + kc - padding_eff. padding_eff = padding when padding_enable=1, else 0.
- Compute coordinates as signed values, at least 34 bits wide.
- r or c outside 0..img_height-1 / 0..img_width-1 (padding region): img_cal = 0. wei_cal is still the kernel element.
- anchor_l ≥ result_height, anchor_c ≥ result_width, buf_l ≥ weight_height*expand or buf_c ≥ weight_width: both outputs = 0.
- Selection is purely combinational from the current inputs. There is no internal counter; the controller sequences the anchors and taps.
- img and weight may change on any cycle. The value sampled is the one present at the capture edge.

## Timing
- Latency 1: inputs valid at edge n drive the outputs after edge n.
- Reset (rst_n=1 at an edge): img_cal = 0, wei_cal = 0. Reset has priority over conv_on.
- conv_on=1: outputs load the selected pair every cycle; throughput is one pair per cycle.
- conv_on=0: behaviour is set by the Configuration macro.
- Reset asserted mid-sequence clears the outputs on the next edge. No other state exists.

## Configuration
- CONV_BUFFER_HOLD_EN defined: conv_on=0 holds the last img_cal/wei_cal.
- CONV_BUFFER_HOLD_EN undefined: conv_on=0 loads 0 into both outputs on each edge.

## Structure
- Package conv_pkg: element bitwidth default, result-dimension formula as a constant function, MSB-first slice-index function. Shared with the MAC and controller blocks.
- One sub-module, conv_pad_fetch: combinational coordinate compute, bounds check and element mux for the image plane.
- The weight mux and output registers stay in conv_buffer.

## Test plan
Default parameters unless stated. img elements 0..15 = 0x0001..0x0010. weight = 0x3C00 ×4.
- Reset held 2 cycles -> img_cal = 0, wei_cal = 0. Release with conv_on=1, anchors 0, taps 0 -> img_cal = 0x0001 and wei_cal = 0x3C00 one edge later.
- anchor (2,2), tap (1,1) -> img_cal = 0x0010. Sweep anchors 0..2 × taps 0..1 -> element (anchor_l+kr)*4 + (anchor_c+kc) + 1 each cycle, 1-cycle latency.
- padding_enable=1, padding=1 (result 5×5): anchor (0,0), tap (0,0) -> img_cal = 0, wei_cal = 0x3C00. Tap (1,1) -> img_cal = 0x0001.
- stride=2 (result 2×2): anchor (1,1), tap (1,1) -> img_cal = element (3,3) = 0x0010. Anchor (2,0) -> both outputs 0.
- expand=2 (distinct weights per channel): buf_l=2, buf_c=0 -> channel 1 kernel (0,0) and image element 16.
- Drop conv_on -> outputs hold (macro defined) or go to 0 (macro undefined). Assert reset mid-sweep -> outputs 0 next edge.
